trap_sequencer: RTL and testbench

- Sequences every privilege-state change for the core: synchronous exceptions, interrupts, MRET and SRET.
- Arbitrates between simultaneous trap sources, drains or flushes the pipeline, and fires the one-cycle handle_* strobes into the CSR/privilege block.
- Computes the redirect PC from mtvec/mepc/sepc and holds a redirect request to fetch until it is accepted.
- Owns the current privilege level.

---
 rtl/trap_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_trap_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// Trap/return sequencer: arbitrates exc > mret > sret > irq, fires one-cycle handle_* strobes, holds redirect until redirect_ack.
// Latency exc->handle 1, exc->redirect 2, mret->redirect 3 cycles; optional TRAP_VECTORED_EN enables vectored interrupt targets.
module trap_sequencer #(
   parameter int REG_WIDTH = 64,
   parameter int NUM_IRQ   = 12
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_IRQ-1:0]   mip,
   input  logic [NUM_IRQ-1:0]   mie,
   input  logic                 mstatus_mie,
   input  logic                 exc_valid,
   input  logic [5:0]           exc_code,
   input  logic [REG_WIDTH-1:0] exc_pc,
   input  logic                 mret_valid,
   input  logic                 sret_valid,
   input  logic [REG_WIDTH-1:0] ret_pc,
   input  logic                 pipe_empty,
   input  logic [REG_WIDTH-1:0] mtvec,
   input  logic [REG_WIDTH-1:0] mepc,
   input  logic [REG_WIDTH-1:0] sepc,
   input  logic [1:0]           ret_priv,
   input  logic                 redirect_ack,
   output logic                 stall_fetch,
   output logic                 flush,
   output logic                 handle_interrupt,
   output logic                 handle_exception,
   output logic                 handle_mret,
   output logic                 handle_sret,
   output logic [REG_WIDTH-1:0] save_pc,
   output logic [1:0]           save_priv,
   output logic [62:0]          exception_code,
   output logic                 redirect_valid,
   output logic [REG_WIDTH-1:0] redirect_pc,
   output logic [1:0]           cur_priv,
   output logic                 busy
);

   typedef enum logic [2:0] {IDLE, DRAIN, COMMIT, RET_WAIT, REDIRECT} state_t;
   typedef enum logic [1:0] {K_EXC, K_IRQ, K_MRET, K_SRET} kind_t;

   state_t               state_q;
   kind_t                kind_q;
   logic [5:0]           cause_q;
   logic [1:0]           cur_priv_q;
   logic                 h_irq_q, h_exc_q, h_mret_q, h_sret_q;
   logic [REG_WIDTH-1:0] save_pc_q;
   logic [1:0]           save_priv_q;
   logic [62:0]          code_q;
   logic                 redirect_valid_q;
   logic [REG_WIDTH-1:0] redirect_pc_q;

   logic                 irq_take;
   logic [5:0]           irq_cause;
   logic [REG_WIDTH-1:0] trap_base;
   logic [REG_WIDTH-1:0] trap_target;

   // Standard interrupt priority 11,3,7,9,1,5; later assignments win, so 11 is applied last.
   function automatic logic [5:0] pick_cause(input logic [NUM_IRQ-1:0] pend);
      logic [63:0] p;
      logic [5:0]  c;
      logic        found;
      p     = 64'(pend);
      c     = 6'd0;
      found = 1'b0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (!found && pend[i]) begin
            c     = 6'(i);
            found = 1'b1;
         end
      end
      if (p[5])  c = 6'd5;
      if (p[1])  c = 6'd1;
      if (p[9])  c = 6'd9;
      if (p[7])  c = 6'd7;
      if (p[3])  c = 6'd3;
      if (p[11]) c = 6'd11;
      return c;
   endfunction

   assign irq_take  = (|(mip & mie)) && ((cur_priv_q != 2'd3) || mstatus_mie);
   assign irq_cause = pick_cause(mip & mie);
   assign trap_base = mtvec & ~REG_WIDTH'(3);

`ifdef TRAP_VECTORED_EN
   assign trap_target = (kind_q == K_IRQ && mtvec[1:0] == 2'b01)
                        ? trap_base + REG_WIDTH'({cause_q, 2'b00}) : trap_base;
`else
   assign trap_target = trap_base;
`endif

   assign flush = ((state_q == IDLE) && (exc_valid || mret_valid || sret_valid)) ||
                  ((state_q == DRAIN) && exc_valid);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= IDLE;
         kind_q           <= K_EXC;
         cause_q          <= 6'd0;
         cur_priv_q       <= 2'd3;
         h_irq_q          <= 1'b0;
         h_exc_q          <= 1'b0;
         h_mret_q         <= 1'b0;
         h_sret_q         <= 1'b0;
         save_pc_q        <= '0;
         save_priv_q      <= 2'd0;
         code_q           <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         // COMMIT-only outputs default low; they are set on the edge that enters COMMIT.
         h_irq_q     <= 1'b0;
         h_exc_q     <= 1'b0;
         h_mret_q    <= 1'b0;
         h_sret_q    <= 1'b0;
         save_pc_q   <= '0;
         save_priv_q <= 2'd0;
         code_q      <= '0;
         case (state_q)
            IDLE: begin
               if (exc_valid) begin
                  kind_q      <= K_EXC;
                  cause_q     <= exc_code;
                  h_exc_q     <= 1'b1;
                  save_pc_q   <= exc_pc;
                  save_priv_q <= cur_priv_q;
                  code_q      <= 63'(exc_code);
                  state_q     <= COMMIT;
               end else if (mret_valid || sret_valid) begin
                  kind_q      <= mret_valid ? K_MRET : K_SRET;
                  cause_q     <= 6'd0;
                  h_mret_q    <= mret_valid;
                  h_sret_q    <= !mret_valid;
                  save_priv_q <= cur_priv_q;
                  state_q     <= COMMIT;
               end else if (irq_take) begin
                  kind_q  <= K_IRQ;
                  cause_q <= irq_cause;
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               // An older faulting instruction pre-empts the pending interrupt.
               if (exc_valid) begin
                  kind_q      <= K_EXC;
                  cause_q     <= exc_code;
                  h_exc_q     <= 1'b1;
                  save_pc_q   <= exc_pc;
                  save_priv_q <= cur_priv_q;
                  code_q      <= 63'(exc_code);
                  state_q     <= COMMIT;
               end else if (!irq_take) begin
                  cause_q <= 6'd0;
                  state_q <= IDLE;
               end else if (pipe_empty) begin
                  h_irq_q     <= 1'b1;
                  save_pc_q   <= ret_pc;
                  save_priv_q <= cur_priv_q;
                  code_q      <= 63'(cause_q);
                  state_q     <= COMMIT;
               end
            end
            COMMIT: begin
               if (kind_q == K_EXC || kind_q == K_IRQ) begin
                  cur_priv_q       <= 2'd3;
                  redirect_pc_q    <= trap_target;
                  redirect_valid_q <= 1'b1;
                  state_q          <= REDIRECT;
               end else begin
                  redirect_pc_q <= (kind_q == K_MRET) ? mepc : sepc;
                  state_q       <= RET_WAIT;
               end
            end
            RET_WAIT: begin
               cur_priv_q       <= ret_priv;
               redirect_valid_q <= 1'b1;
               state_q          <= REDIRECT;
            end
            REDIRECT: begin
               if (redirect_ack) begin
                  redirect_valid_q <= 1'b0;
                  state_q          <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy             = (state_q != IDLE);
   assign stall_fetch      = busy;
   assign handle_interrupt = h_irq_q;
   assign handle_exception = h_exc_q;
   assign handle_mret      = h_mret_q;
   assign handle_sret      = h_sret_q;
   assign save_pc          = save_pc_q;
   assign save_priv        = save_priv_q;
   assign exception_code   = code_q;
   assign redirect_valid   = redirect_valid_q;
   assign redirect_pc      = redirect_pc_q;
   assign cur_priv         = cur_priv_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: reset, return, exception, interrupt drain, arbitration and pre-emption cases.
module tb_trap_sequencer;

   localparam int RW = 64;
   localparam int NI = 12;

   logic          clk = 1'b0;
   logic          reset;
   logic [NI-1:0] mip, mie;
   logic          mstatus_mie, exc_valid, mret_valid, sret_valid, pipe_empty, redirect_ack;
   logic [5:0]    exc_code;
   logic [RW-1:0] exc_pc, ret_pc, mtvec, mepc, sepc;
   logic [1:0]    ret_priv;
   logic          stall_fetch, flush, handle_interrupt, handle_exception, handle_mret, handle_sret;
   logic [RW-1:0] save_pc, redirect_pc;
   logic [1:0]    save_priv, cur_priv;
   logic [62:0]   exception_code;
   logic          redirect_valid, busy;

   int checks   = 0;
   int failures = 0;

   trap_sequencer #(.REG_WIDTH(RW), .NUM_IRQ(NI)) dut (
      .clk(clk), .reset(reset), .mip(mip), .mie(mie), .mstatus_mie(mstatus_mie),
      .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
      .mret_valid(mret_valid), .sret_valid(sret_valid), .ret_pc(ret_pc),
      .pipe_empty(pipe_empty), .mtvec(mtvec), .mepc(mepc), .sepc(sepc),
      .ret_priv(ret_priv), .redirect_ack(redirect_ack),
      .stall_fetch(stall_fetch), .flush(flush), .handle_interrupt(handle_interrupt),
      .handle_exception(handle_exception), .handle_mret(handle_mret), .handle_sret(handle_sret),
      .save_pc(save_pc), .save_priv(save_priv), .exception_code(exception_code),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .cur_priv(cur_priv), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are then driven 2 time units after the edge and checked 1 later.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      reset = 1'b1; mip = '0; mie = '0; mstatus_mie = 1'b0;
      exc_valid = 1'b0; exc_code = '0; exc_pc = '0; mret_valid = 1'b0; sret_valid = 1'b0;
      ret_pc = '0; pipe_empty = 1'b1; mtvec = '0; mepc = '0; sepc = '0; ret_priv = '0;
      redirect_ack = 1'b0;
      tick(); tick();
      reset = 1'b0;
      #1;
      chk("rst_priv", cur_priv, 2'd3);
      chk("rst_busy", busy, 1'b0);
      chk("rst_stall", stall_fetch, 1'b0);
      chk("rst_rv", redirect_valid, 1'b0);
      chk("rst_code", exception_code, 63'd0);

      // MRET to S-mode
      tick();
      mret_valid = 1'b1; mepc = 64'h4000; ret_priv = 2'd1;
      #1 chk("mret_flush", flush, 1'b1);
      tick(); mret_valid = 1'b0;
      #1 chk("mret_handle", handle_mret, 1'b1);
      chk("mret_save_priv", save_priv, 2'd3);
      chk("mret_busy", busy, 1'b1);
      tick();
      #1 chk("mret_retwait_rv", redirect_valid, 1'b0);
      chk("mret_retwait_handle", handle_mret, 1'b0);
      tick();
      #1 chk("mret_rv", redirect_valid, 1'b1);
      chk("mret_rpc", redirect_pc, 64'h4000);
      chk("mret_priv", cur_priv, 2'd1);
      tick();
      #1 chk("mret_rv_held", redirect_valid, 1'b1);
      redirect_ack = 1'b1;
      tick(); redirect_ack = 1'b0;
      #1 chk("mret_idle", busy, 1'b0);
      chk("mret_rv_drop", redirect_valid, 1'b0);

      // SRET to U-mode
      sret_valid = 1'b1; sepc = 64'h2000; ret_priv = 2'd0;
      tick(); sret_valid = 1'b0;
      #1 chk("sret_handle", handle_sret, 1'b1);
      chk("sret_save_priv", save_priv, 2'd1);
      tick(); tick();
      #1 chk("sret_rpc", redirect_pc, 64'h2000);
      chk("sret_priv", cur_priv, 2'd0);
      redirect_ack = 1'b1;
      tick(); redirect_ack = 1'b0;

      // Exception from U-mode
      mtvec = 64'h8000_0101; exc_valid = 1'b1; exc_code = 6'd2; exc_pc = 64'h8000_0010;
      #1 chk("exc_flush", flush, 1'b1);
      tick(); exc_valid = 1'b0;
      #1 chk("exc_handle", handle_exception, 1'b1);
      chk("exc_save_pc", save_pc, 64'h8000_0010);
      chk("exc_save_priv", save_priv, 2'd0);
      chk("exc_code", exception_code, 63'd2);
      chk("exc_no_irq", handle_interrupt, 1'b0);
      tick();
      #1 chk("exc_rv", redirect_valid, 1'b1);
      chk("exc_rpc", redirect_pc, 64'h8000_0100);
      chk("exc_priv", cur_priv, 2'd3);
      chk("exc_save_pc_clr", save_pc, 64'd0);
      tick();
      #1 chk("exc_rpc_held", redirect_pc, 64'h8000_0100);
      chk("exc_rv_held", redirect_valid, 1'b1);
      redirect_ack = 1'b1;
      tick(); redirect_ack = 1'b0;

      // Interrupt with 4-cycle drain
      mtvec = 64'h1001; mip = 12'h0A8; mie = 12'h0A8; mstatus_mie = 1'b1;
      pipe_empty = 1'b0; ret_pc = 64'h3000;
      #1 chk("irq_noflush", flush, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         #1 chk("irq_drain_busy", busy, 1'b1);
         chk("irq_drain_nohandle", handle_interrupt, 1'b0);
      end
      tick(); pipe_empty = 1'b1;
      #1 chk("irq_drain4_nohandle", handle_interrupt, 1'b0);
      tick(); mip = '0;
      #1 chk("irq_handle", handle_interrupt, 1'b1);
      chk("irq_code", exception_code, 63'd3);
      chk("irq_save_pc", save_pc, 64'h3000);
      chk("irq_save_priv", save_priv, 2'd3);
      tick();
`ifdef TRAP_VECTORED_EN
      #1 chk("irq_rpc", redirect_pc, 64'h100C);
`else
      #1 chk("irq_rpc", redirect_pc, 64'h1000);
`endif
      chk("irq_rv", redirect_valid, 1'b1);
      redirect_ack = 1'b1;
      tick(); redirect_ack = 1'b0;

      // Exception, MRET and interrupt together: exception wins
      mip = 12'h800; mie = 12'h800; exc_valid = 1'b1; exc_code = 6'd7; exc_pc = 64'h500;
      mret_valid = 1'b1;
      #1 chk("arb_flush", flush, 1'b1);
      tick(); exc_valid = 1'b0; mret_valid = 1'b0;
      #1 chk("arb_exc", handle_exception, 1'b1);
      chk("arb_no_mret", handle_mret, 1'b0);
      chk("arb_no_irq", handle_interrupt, 1'b0);
      chk("arb_code", exception_code, 63'd7);
      tick();
      #1 chk("arb_rpc", redirect_pc, 64'h1000);
      chk("arb_no_mret2", handle_mret, 1'b0);
      chk("arb_no_irq2", handle_interrupt, 1'b0);
      mip = '0; redirect_ack = 1'b1;
      tick(); redirect_ack = 1'b0;
      #1 chk("arb_idle", busy, 1'b0);

      // Exception pre-empts an interrupt in DRAIN
      mip = 12'h002; mie = 12'h002; pipe_empty = 1'b0;
      tick();
      #1 chk("pre_drain", busy, 1'b1);
      exc_valid = 1'b1; exc_code = 6'd5; exc_pc = 64'h600;
      #1 chk("pre_flush", flush, 1'b1);
      tick(); exc_valid = 1'b0; mip = '0;
      #1 chk("pre_exc", handle_exception, 1'b1);
      chk("pre_no_irq", handle_interrupt, 1'b0);
      chk("pre_code", exception_code, 63'd5);
      chk("pre_save_pc", save_pc, 64'h600);
      tick();
      #1 chk("pre_no_irq2", handle_interrupt, 1'b0);
      chk("pre_rpc", redirect_pc, 64'h1000);
      redirect_ack = 1'b1;
      tick(); redirect_ack = 1'b0;

      // Interrupt withdrawn during DRAIN: abandon with no strobe
      mip = 12'h020; mie = 12'h020;
      tick(); mip = '0;
      #1 chk("abn_drain", busy, 1'b1);
      tick();
      #1 chk("abn_idle", busy, 1'b0);
      chk("abn_no_irq", handle_interrupt, 1'b0);

      // Masked in M-mode when mstatus_mie=0
      mip = 12'h080; mie = 12'h080; mstatus_mie = 1'b0;
      tick();
      #1 chk("mask_idle", busy, 1'b0);

      // Asynchronous reset mid-DRAIN
      mstatus_mie = 1'b1;
      tick();
      #1 chk("rst_pre_drain", busy, 1'b1);
      reset = 1'b1;
      #1 chk("rst_async_busy", busy, 1'b0);
      tick();
      #1 chk("rst_mid_priv", cur_priv, 2'd3);
      chk("rst_mid_stall", stall_fetch, 1'b0);
      chk("rst_mid_rv", redirect_valid, 1'b0);
      reset = 1'b0; mip = '0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
